// File: rtl/pipeline_ctrl.sv
// Control unit for a three-stage ID/EX/WB pipeline: fetch pc, hazard stall,
// branch flush, stage valids and retired count. Define PIPE_CTRL_FWD_EN to forward instead of stall.
module pipeline_ctrl #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned RA_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            imem_ack,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_we,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  output logic            imem_req,
  output logic [PC_W-1:0] pc,
  output logic            stall,
  output logic            flush,
  output logic            v_id,
  output logic            v_ex,
  output logic            v_wb,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [15:0]     retired
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            v_id_q, v_id_d, v_ex_q, v_ex_d, v_wb_q, v_wb_d;
  logic [RA_W-1:0] ex_rd_q, ex_rd_d, wb_rd_q, wb_rd_d;
  logic            ex_we_q, ex_we_d, wb_we_q, wb_we_d;
  logic [15:0]     retired_q, retired_d;

  logic hz_ex_a, hz_ex_b, hz_wb_a, hz_wb_b;
  logic hazard_ex, hazard_wb;

  // Register 0 is hardwired, so a write to it never conflicts with a read.
  always_comb begin
    hz_ex_a   = v_id_q & v_ex_q & ex_we_q & (ex_rd_q != '0) & (ex_rd_q == id_rs1);
    hz_ex_b   = v_id_q & v_ex_q & ex_we_q & (ex_rd_q != '0) & (ex_rd_q == id_rs2);
    hz_wb_a   = v_id_q & v_wb_q & wb_we_q & (wb_rd_q != '0) & (wb_rd_q == id_rs1);
    hz_wb_b   = v_id_q & v_wb_q & wb_we_q & (wb_rd_q != '0) & (wb_rd_q == id_rs2);
    hazard_ex = hz_ex_a | hz_ex_b;
    hazard_wb = hz_wb_a | hz_wb_b;
  end

  always_comb begin
    flush = v_ex_q & ex_taken;
`ifdef PIPE_CTRL_FWD_EN
    stall = 1'b0;
    fwd_a = hz_ex_a ? 2'b01 : (hz_wb_a ? 2'b10 : 2'b00);
    fwd_b = hz_ex_b ? 2'b01 : (hz_wb_b ? 2'b10 : 2'b00);
`else
    stall = (hazard_ex | hazard_wb) & ~flush;
    fwd_a = 2'b00;
    fwd_b = 2'b00;
`endif
  end

  always_comb begin
    pc_d    = pc_q;
    v_id_d  = v_id_q;
    v_ex_d  = v_id_q;
    ex_rd_d = id_rd;
    ex_we_d = id_we;
    if (flush) begin
      pc_d    = ex_target;
      v_id_d  = 1'b0;
      v_ex_d  = 1'b0;
      ex_we_d = 1'b0;
    end else if (stall) begin
      v_ex_d  = 1'b0;
      ex_we_d = 1'b0;
    end else begin
      v_id_d = imem_ack;
      if (imem_ack) pc_d = pc_q + PC_W'(1);
    end
    // WB always drains from EX, regardless of stall or flush.
    v_wb_d    = v_ex_q;
    wb_rd_d   = ex_rd_q;
    wb_we_d   = ex_we_q;
    retired_d = retired_q + {15'b0, v_wb_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      v_id_q    <= 1'b0;
      v_ex_q    <= 1'b0;
      v_wb_q    <= 1'b0;
      ex_rd_q   <= '0;
      ex_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      v_id_q    <= v_id_d;
      v_ex_q    <= v_ex_d;
      v_wb_q    <= v_wb_d;
      ex_rd_q   <= ex_rd_d;
      ex_we_q   <= ex_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req = rst_n;
  assign pc       = pc_q;
  assign v_id     = v_id_q;
  assign v_ex     = v_ex_q;
  assign v_wb     = v_wb_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: fetch, hazard stall (or forwarding with
// PIPE_CTRL_FWD_EN), branch flush, pc wrap with fetch gaps, async reset.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, imem_ack, id_we, ex_taken;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic [7:0] ex_target;
  logic       imem_req, stall, flush, v_id, v_ex, v_wb;
  logic [7:0] pc;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] retired;

  int n_assert = 0;
  int n_fail   = 0;

  pipeline_ctrl #(.PC_W(8), .RA_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ack(imem_ack),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_we(id_we),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .imem_req(imem_req), .pc(pc), .stall(stall), .flush(flush),
    .v_id(v_id), .v_ex(v_ex), .v_wb(v_wb),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    imem_ack = 1'b0; id_we = 1'b0; ex_taken = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_target = '0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},      32'(pc), 0);
    chk({tag, "_vid"},     32'(v_id), 0);
    chk({tag, "_vex"},     32'(v_ex), 0);
    chk({tag, "_vwb"},     32'(v_wb), 0);
    chk({tag, "_retired"}, 32'(retired), 0);
    chk({tag, "_req"},     32'(imem_req), 0);
    chk({tag, "_stall"},   32'(stall), 0);
    chk({tag, "_flush"},   32'(flush), 0);
    chk({tag, "_fwd_a"},   32'(fwd_a), 0);
    chk({tag, "_fwd_b"},   32'(fwd_b), 0);
  endtask

  initial begin
    clr_inputs();
    rst_n = 1'b0;
    #2;
    chk_reset_state("rst");

    // Straight-line fetch after release
    tick();
    rst_n = 1'b1; imem_ack = 1'b1;
    #1;
    chk("fetch_req", 32'(imem_req), 1);
    chk("fetch_pc0", 32'(pc), 0);
    tick(); chk("fetch_pc1", 32'(pc), 1); chk("fetch_vid1", 32'(v_id), 1);
    tick(); chk("fetch_pc2", 32'(pc), 2); chk("fetch_vex2", 32'(v_ex), 1);
    tick(); chk("fetch_pc3", 32'(pc), 3); chk("fetch_vwb3", 32'(v_wb), 1);
    chk("fetch_ret3", 32'(retired), 0);
    tick(); chk("fetch_pc4", 32'(pc), 4); chk("fetch_ret4", 32'(retired), 1);
    imem_ack = 1'b0;
    tick(); chk("idle_pc", 32'(pc), 4); chk("idle_vid", 32'(v_id), 0);
    chk("fetch_ret5", 32'(retired), 2);
    tick(); tick();
    chk("drain_ret", 32'(retired), 4); chk("drain_vwb", 32'(v_wb), 0);

    // RAW hazard on rs1 against r3
    do_reset();
    imem_ack = 1'b1; id_rd = 3'd3; id_we = 1'b1;
    tick(); tick();
    id_rd = 3'd0; id_we = 1'b0; id_rs1 = 3'd3; id_rs2 = 3'd5;
    #1;
`ifdef PIPE_CTRL_FWD_EN
    chk("fwd_ex_stall", 32'(stall), 0);
    chk("fwd_ex_a",     32'(fwd_a), 1);
    chk("fwd_ex_b",     32'(fwd_b), 0);
    tick();
    chk("fwd_wb_pc",    32'(pc), 3);
    chk("fwd_wb_stall", 32'(stall), 0);
    chk("fwd_wb_a",     32'(fwd_a), 2);
`else
    chk("haz_ex_stall", 32'(stall), 1);
    chk("haz_ex_fwd_a", 32'(fwd_a), 0);
    tick();
    chk("haz_wb_pc",    32'(pc), 2);
    chk("haz_wb_vid",   32'(v_id), 1);
    chk("haz_wb_vex",   32'(v_ex), 0);
    chk("haz_wb_vwb",   32'(v_wb), 1);
    chk("haz_wb_stall", 32'(stall), 1);
    tick();
    chk("haz_end_pc",    32'(pc), 2);
    chk("haz_end_vex",   32'(v_ex), 0);
    chk("haz_end_stall", 32'(stall), 0);
    tick();
    chk("haz_go_pc",  32'(pc), 3);
    chk("haz_go_vex", 32'(v_ex), 1);
`endif

    // r0 destination never hazards; rs2 path hazards
    do_reset();
    imem_ack = 1'b1; id_rd = 3'd0; id_we = 1'b1;
    tick(); tick();
    id_we = 1'b0; id_rs1 = 3'd0; id_rs2 = 3'd0;
    #1;
    chk("r0_stall", 32'(stall), 0);
    do_reset();
    imem_ack = 1'b1; id_rd = 3'd6; id_we = 1'b1;
    tick(); tick();
    id_we = 1'b0; id_rd = 3'd0; id_rs2 = 3'd6;
    #1;
`ifdef PIPE_CTRL_FWD_EN
    chk("rs2_fwd_b", 32'(fwd_b), 1);
`else
    chk("rs2_stall", 32'(stall), 1);
`endif

    // Branch while a hazard is active
    do_reset();
    imem_ack = 1'b1; id_rd = 3'd3; id_we = 1'b1;
    tick(); tick();
    id_rd = 3'd0; id_we = 1'b0; id_rs1 = 3'd3;
    ex_taken = 1'b1; ex_target = 8'h40;
    #1;
    chk("br_flush", 32'(flush), 1);
    chk("br_stall", 32'(stall), 0);
    tick();
    chk("br_pc",  32'(pc), 'h40);
    chk("br_vid", 32'(v_id), 0);
    chk("br_vex", 32'(v_ex), 0);
    chk("br_vwb", 32'(v_wb), 1);
    chk("br_unqualified_flush", 32'(flush), 0);
    ex_taken = 1'b0;

    // Fetch gap at pc 0xFF, then wrap
    do_reset();
    imem_ack = 1'b1;
    tick(); tick();
    ex_taken = 1'b1; ex_target = 8'hFF;
    tick();
    ex_taken = 1'b0; imem_ack = 1'b0;
    chk("wrap_pc_ff", 32'(pc), 'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_pc",  32'(pc), 'hFF);
      chk("gap_vid", 32'(v_id), 0);
    end
    imem_ack = 1'b1;
    tick();
    chk("wrap_pc_00", 32'(pc), 0);
    chk("wrap_vid",   32'(v_id), 1);

    // Asynchronous reset mid-stream
    do_reset();
    imem_ack = 1'b1;
    repeat (10) tick();
    chk("pre_rst_ret", 32'(retired), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("arst");
    #1;
    rst_n = 1'b1;
    #1;
    chk("arst_first_pc", 32'(pc), 0);
    tick();
    chk("arst_next_pc",  32'(pc), 1);
    chk("arst_next_vid", 32'(v_id), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
